ram_arb_2p: RTL and testbench
=============================

RAM_ARB_2P -- requirements
Module: ram_arb_2p

Interface
REQ-001 Parameter DATA_W, default 8, word width of the shared RAM.
REQ-002 Parameter ADDR_W, default 4, address width (2**ADDR_W = 16 words).
REQ-003 Parameter MAX_BURST, default 4, max consecutive grants to one locked requester.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Ports req_a / req_b  input  1  access request from requester A / B.
REQ-007 Ports we_a / we_b  input  1  1 = write, 0 = read; qualified by req_x.
REQ-008 Ports addr_a / addr_b  input  ADDR_W  target word address.
REQ-009 Ports wdata_a / wdata_b  input  DATA_W  write data.
REQ-010 Ports lock_a / lock_b  input  1  request to keep the grant on following cycles.
REQ-011 Ports gnt_a / gnt_b  output  1  combinational grant; the access is accepted this cycle.
REQ-012 Ports rvalid_a / rvalid_b  output  1  read data for that requester present on rdata.
REQ-013 Port rdata  output  DATA_W  read data, shared by both requesters.

Function
REQ-014 At most one of gnt_a, gnt_b SHALL be high in any cycle; a grant is issued only to an asserted req_x.
REQ-015 A granted access (req_x & gnt_x) SHALL be presented to the RAM in the same cycle; writes commit at that clock edge.
REQ-016 A granted read SHALL produce rvalid_x = 1 and rdata = stored word exactly one cycle later (latency 1); rdata is undefined when neither rvalid is high.
REQ-017 A granted write SHALL produce no rvalid pulse.
REQ-018 Arbitration SHALL be round-robin: 1-bit priority pointer; with both requests, the pointed-to requester wins; after any non-locked grant the pointer moves to the other requester.
REQ-019 With only one request pending, it SHALL be granted regardless of the pointer.
REQ-020 FSM states: IDLE_RR (round-robin), LOCK_A, LOCK_B; IDLE_RR -> LOCK_x when x is granted with lock_x = 1.
REQ-021 In LOCK_x, x SHALL have absolute priority while req_x & lock_x; exit to IDLE_RR with pointer at the other requester when lock_x or req_x drops.
REQ-022 A 2-bit-minimum burst counter SHALL count consecutive grants in a lock; on reaching MAX_BURST with the other requester pending, the lock SHALL be broken: exit to IDLE_RR, pointer = other, other granted next cycle.
REQ-023 If MAX_BURST is reached and the other requester is idle, the counter SHALL saturate and the lock continue.
REQ-024 Write then read of the same address on consecutive cycles SHALL return the new data.
REQ-025 A read issued in cycle N followed by a write to the same address in N+1 SHALL return the old data on rvalid in N+1.
REQ-026 Address wrap: addresses 0..15 only; no out-of-range behaviour exists.

Reset
REQ-027 During rst = 1: gnt_a = gnt_b = 0, no RAM write occurs, FSM = IDLE_RR, pointer = A, burst count = 0.
REQ-028 rvalid_a = rvalid_b = 0 on the cycle after any cycle with rst = 1, including a read pending when rst asserts (dropped, not replayed).
REQ-029 RAM contents SHALL not be cleared by reset; unwritten words read as X.

Structure
REQ-030 Package ram_arb_pkg SHALL hold the FSM state enum, requester-id encoding (A = 0, B = 1) and default DATA_W/ADDR_W/MAX_BURST.
REQ-031 Storage SHALL be one sub-module ram_16x8_sp: single port, synchronous write, registered read address, parameterised by DATA_W/ADDR_W.

Verification
REQ-032 After reset, A writes 0x5A to addr 3, then A reads addr 3 -> rvalid_a one cycle after read grant, rdata = 0x5A, rvalid_b = 0.
REQ-033 A and B request reads every cycle, no lock -> grants alternate A,B,A,B starting with A; no cycle with both grants.
REQ-034 A locked with continuous reads, B requesting -> A granted exactly 4 cycles, then B granted; pointer then favours A.
REQ-035 B read of addr 7 (holding 0x11) in cycle N, A write 0x22 to addr 7 in N+1 -> rvalid_b in N+1 with rdata = 0x11; next read of addr 7 returns 0x22.
REQ-036 rst asserted the cycle after a granted read -> no rvalid pulse; gnt outputs 0 while rst high; first post-reset contention grants A.
REQ-037 Only B requests, alone, for 3 cycles with pointer at A -> B granted all 3 cycles.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// Holds the FSM state encoding, requester ids and default sizes.
package ram_arb_pkg;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_ADDR_W    = 4;
   localparam int DEF_MAX_BURST = 4;

   typedef enum logic [1:0] {
      IDLE_RR = 2'd0,
      LOCK_A  = 2'd1,
      LOCK_B  = 2'd2
   } arb_state_e;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_e;

   // Burst counter must hold MAX_BURST and is never narrower than 2 bits.
   function automatic int burst_width(input int max_burst);
      int w;
      w = $clog2(max_burst + 1);
      return (w < 2) ? 2 : w;
   endfunction

endpackage

// File: rtl/ram_16x8_sp.sv
// Single-port RAM: synchronous write, registered read address.
// Contents are never cleared; unwritten words read as X.
module ram_16x8_sp
   import ram_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_r [2**ADDR_W];
   logic [ADDR_W-1:0] raddr_r;

   // Write commits at the edge; the read address is held only for reads so a
   // following write to the same word still shows the old data for one cycle.
   always_ff @(posedge clk) begin
      if (en && we) begin
         mem_r[addr] <= wdata;
      end
      if (en && !we) begin
         raddr_r <= addr;
      end
   end

   assign rdata = mem_r[raddr_r];

endmodule

// File: rtl/ram_arb_2p.sv
// Two-requester round-robin arbiter with lock/burst limiting in front of a
// shared single-port RAM. Grants are combinational; read data has latency 1.
module ram_arb_2p
   import ram_arb_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_a,
   input  logic              req_b,
   input  logic              we_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_a,
   input  logic [DATA_W-1:0] wdata_b,
   input  logic              lock_a,
   input  logic              lock_b,
   output logic              gnt_a,
   output logic              gnt_b,
   output logic              rvalid_a,
   output logic              rvalid_b,
   output logic [DATA_W-1:0] rdata
);

   localparam int                 BURST_W   = burst_width(MAX_BURST);
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
   localparam logic [BURST_W-1:0] BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};

   arb_state_e          state_r, state_s;
   req_id_e             ptr_r, ptr_s;
   logic [BURST_W-1:0]  burst_r, burst_s, burst_inc_s, burst_new_s;
   logic                gnt_a_s, gnt_b_s, held_s;
   logic                rvalid_a_r, rvalid_b_r;
   logic                ram_en_s, ram_we_s;
   logic [ADDR_W-1:0]   ram_addr_s;
   logic [DATA_W-1:0]   ram_wdata_s;

   // Grant selection and next-state for the arbitration FSM.
   always_comb begin
      state_s     = state_r;
      ptr_s       = ptr_r;
      burst_s     = burst_r;
      gnt_a_s     = 1'b0;
      gnt_b_s     = 1'b0;
      held_s      = 1'b0;
      burst_new_s = BURST_ONE;
      burst_inc_s = (burst_r >= BURST_MAX) ? BURST_MAX : burst_r + BURST_ONE;

      case (state_r)
         IDLE_RR: begin
            gnt_a_s = req_a && (!req_b || ptr_r == REQ_A);
            gnt_b_s = req_b && (!req_a || ptr_r == REQ_B);
         end
         LOCK_A: begin
            if (req_a && lock_a) begin
               held_s  = 1'b1;
               gnt_a_s = 1'b1;
            end else begin
               // Leaving the lock: B holds priority this cycle.
               gnt_a_s = req_a && !req_b;
               gnt_b_s = req_b;
               ptr_s   = REQ_B;
            end
         end
         LOCK_B: begin
            if (req_b && lock_b) begin
               held_s  = 1'b1;
               gnt_b_s = 1'b1;
            end else begin
               gnt_b_s = req_b && !req_a;
               gnt_a_s = req_a;
               ptr_s   = REQ_A;
            end
         end
         default: begin
            state_s = IDLE_RR;
            ptr_s   = REQ_A;
         end
      endcase

      if (rst) begin
         gnt_a_s = 1'b0;
         gnt_b_s = 1'b0;
      end else begin
         held_s = held_s;
      end

      burst_new_s = held_s ? burst_inc_s : BURST_ONE;

      if (gnt_a_s) begin
         if (lock_a && !(burst_new_s == BURST_MAX && req_b)) begin
            state_s = LOCK_A;
            burst_s = burst_new_s;
         end else begin
            state_s = IDLE_RR;
            ptr_s   = REQ_B;
            burst_s = '0;
         end
      end else if (gnt_b_s) begin
         if (lock_b && !(burst_new_s == BURST_MAX && req_a)) begin
            state_s = LOCK_B;
            burst_s = burst_new_s;
         end else begin
            state_s = IDLE_RR;
            ptr_s   = REQ_A;
            burst_s = '0;
         end
      end else begin
         state_s = IDLE_RR;
         burst_s = '0;
      end
   end

   // FSM, pointer and burst counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE_RR;
         ptr_r   <= REQ_A;
         burst_r <= '0;
      end else begin
         state_r <= state_s;
         ptr_r   <= ptr_s;
         burst_r <= burst_s;
      end
   end

   // Read responses trail their grant by one cycle; reset drops any in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_a_r <= 1'b0;
         rvalid_b_r <= 1'b0;
      end else begin
         rvalid_a_r <= gnt_a_s && !we_a;
         rvalid_b_r <= gnt_b_s && !we_b;
      end
   end

   assign gnt_a    = gnt_a_s;
   assign gnt_b    = gnt_b_s;
   assign rvalid_a = rvalid_a_r && !rst;
   assign rvalid_b = rvalid_b_r && !rst;

   assign ram_en_s    = gnt_a_s || gnt_b_s;
   assign ram_we_s    = gnt_b_s ? we_b    : we_a;
   assign ram_addr_s  = gnt_b_s ? addr_b  : addr_a;
   assign ram_wdata_s = gnt_b_s ? wdata_b : wdata_a;

   ram_16x8_sp #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en_s),
      .we    (ram_we_s),
      .addr  (ram_addr_s),
      .wdata (ram_wdata_s),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_ram_arb_2p.sv
// Directed bench for ram_arb_2p: grants checked per cycle against hand-computed
// values; read responses checked by a scoreboard monitor.
module tb_ram_arb_2p;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_a, req_b, we_a, we_b, lock_a, lock_b;
   logic [3:0] addr_a, addr_b;
   logic [7:0] wdata_a, wdata_b;
   logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
   logic [7:0] rdata;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [8:0] exp_q [$];

   always #5 clk = ~clk;

   ram_arb_2p dut (
      .clk      (clk),
      .rst      (rst),
      .req_a    (req_a),
      .req_b    (req_b),
      .we_a     (we_a),
      .we_b     (we_b),
      .addr_a   (addr_a),
      .addr_b   (addr_b),
      .wdata_a  (wdata_a),
      .wdata_b  (wdata_b),
      .lock_a   (lock_a),
      .lock_b   (lock_b),
      .gnt_a    (gnt_a),
      .gnt_b    (gnt_b),
      .rvalid_a (rvalid_a),
      .rvalid_b (rvalid_b),
      .rdata    (rdata)
   );

   task automatic set_a(input logic r, input logic w, input logic lk,
                        input logic [3:0] ad, input logic [7:0] d);
      req_a = r; we_a = w; lock_a = lk; addr_a = ad; wdata_a = d;
   endtask

   task automatic set_b(input logic r, input logic w, input logic lk,
                        input logic [3:0] ad, input logic [7:0] d);
      req_b = r; we_b = w; lock_b = lk; addr_b = ad; wdata_b = d;
   endtask

   // One cycle: check grants mid-cycle, queue the expected read response.
   task automatic tick(input logic ega, input logic egb, input logic push,
                       input logic who, input logic [7:0] data);
      @(negedge clk);
      n_checks++;
      if (gnt_a !== ega || gnt_b !== egb) begin
         n_fail++;
         $display("FAIL grant t=%0t: gnt_a/gnt_b=%b/%b required %b/%b",
                  $time, gnt_a, gnt_b, ega, egb);
      end
      if (push) begin
         exp_q.push_back({who, data});
      end
      @(posedge clk);
      #1;
   endtask

   // Response monitor.
   always @(negedge clk) begin
      logic [8:0] e;
      n_checks++;
      if (gnt_a && gnt_b) begin
         n_fail++;
         $display("FAIL both_gnt t=%0t: gnt_a=1 gnt_b=1 required at most one", $time);
      end
      if (rvalid_a || rvalid_b) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rvalid t=%0t: rvalid_a/b=%b/%b required 0/0",
                     $time, rvalid_a, rvalid_b);
         end else begin
            e = exp_q.pop_front();
            if ((rvalid_a && rvalid_b) || ({rvalid_b, rdata} !== e)) begin
               n_fail++;
               $display("FAIL rdata t=%0t: rvalid_a/b=%b/%b rdata=%h required port %s rdata=%h",
                        $time, rvalid_a, rvalid_b, rdata, e[8] ? "B" : "A", e[7:0]);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      set_a(1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
      set_b(1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      rst = 1'b0;

      // Write 0x5A to addr 3 then read it back.
      set_b(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      set_a(1'b1, 1'b1, 1'b0, 4'd3, 8'h5A);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      set_a(1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
      tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
      set_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      // Fill addr 7, 1, 2 (single requesters).
      set_b(1'b1, 1'b1, 1'b0, 4'd7, 8'h11);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      set_b(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      set_a(1'b1, 1'b1, 1'b0, 4'd1, 8'h33);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      set_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      set_b(1'b1, 1'b1, 1'b0, 4'd2, 8'h44);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

      // Contention without lock alternates A,B,A,B.
      set_a(1'b1, 1'b0, 1'b0, 4'd1, 8'h00);
      set_b(1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h33);
         tick(1'b0, 1'b1, 1'b1, 1'b1, 8'h44);
      end

      // A locked: 4 grants, then B, then A again.
      set_a(1'b1, 1'b0, 1'b1, 4'd3, 8'h00);
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
      end
      tick(1'b0, 1'b1, 1'b1, 1'b1, 8'h44);
      set_a(1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
      tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
      set_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      set_b(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      // Saturated lock continues while B idle; B arrival breaks it.
      set_a(1'b1, 1'b1, 1'b1, 4'd5, 8'h66);
      for (int i = 0; i < 6; i++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      end
      set_b(1'b1, 1'b0, 1'b0, 4'd5, 8'h00);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      tick(1'b0, 1'b1, 1'b1, 1'b1, 8'h66);
      set_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      set_b(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      // Read-before-write returns old data; next read returns new data.
      set_b(1'b1, 1'b0, 1'b0, 4'd7, 8'h00);
      tick(1'b0, 1'b1, 1'b1, 1'b1, 8'h11);
      set_b(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      set_a(1'b1, 1'b1, 1'b0, 4'd7, 8'h22);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      set_a(1'b1, 1'b0, 1'b0, 4'd7, 8'h00);
      tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h22);

      // B alone with pointer at A: granted every cycle.
      set_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      set_b(1'b1, 1'b1, 1'b0, 4'd8, 8'h77);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      set_b(1'b1, 1'b0, 1'b0, 4'd8, 8'h00);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b1, 1'b1, 1'b1, 8'h77);
      end

      // Reset right after a granted read: response dropped, A wins afterwards.
      set_b(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      set_a(1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
      tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      rst = 1'b1;
      set_b(1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      rst = 1'b0;
      tick(1'b1, 1'b0, 1'b1, 1'b0, 8'h5A);
      tick(1'b0, 1'b1, 1'b1, 1'b1, 8'h44);
      set_a(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      set_b(1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_rvalid: %0d responses outstanding, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
